// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: counting modes,
// counter direction encoding and the per-channel phase offset helper.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Evenly spaced phase offset of channel ch over a 2**width counter range.
  function automatic int unsigned stagger_offset(input int unsigned ch,
                                                 input int unsigned width,
                                                 input int unsigned channels);
    return ch * ((32'd1 << width) / channels);
  endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Control/status bundle between the register front end (master) and the
// PWM generator (slave). Names are from the generator's point of view.
interface pwm_multichannel_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  logic                      i_en;
  logic                      i_mode;
  logic [CHANNELS*WIDTH-1:0] i_d_c;
  logic                      i_load;
  logic                      o_pending;
  logic                      o_period_end;
  logic [CHANNELS-1:0]       o_out;

  modport master (
    output i_en, i_mode, i_d_c, i_load,
    input  o_pending, o_period_end, o_out
  );

  modport slave (
    input  i_en, i_mode, i_d_c, i_load,
    output o_pending, o_period_end, o_out
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, compare against the (possibly
// phase-shifted) shared counter, and the registered output.
module pwm_channel #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_boundary,
  input  logic [WIDTH-1:0] i_duty,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_out
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_out;

  // Shadow captures every load; the last load before a boundary wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_duty;
    end
  end

  // Active duty changes only at a boundary, or immediately while stopped.
  // A load coinciding with the boundary bypasses the shadow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active <= '0;
    end else if (!i_en) begin
      if (i_load) begin
        r_active <= i_duty;
      end
    end else if (i_boundary) begin
      r_active <= i_load ? i_duty : r_shadow;
    end
  end

  // Registered compare; forced low while stopped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out <= 1'b0;
    end else begin
      r_out <= i_en && (i_cnt < r_active);
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter (edge- or
// center-aligned) feeding CHANNELS compare channels with boundary-synchronous
// duty updates.
// Build option: define PWM_PHASE_STAGGER_EN to spread the edge-aligned
// channel phases evenly over the period.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pwm_multichannel_if.slave  bus
);

  localparam logic [WIDTH-1:0] L_CNT_MAX = '1;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  dir_t             r_dir;
  dir_t             w_dir_next;
  logic             r_mode_q;
  logic             r_pending;
  logic             w_boundary;
  logic [WIDTH-1:0] w_cnt_ch [CHANNELS];
  logic [CHANNELS-1:0] w_out;

  // Last cycle of the period for the mode latched at the previous boundary.
  always_comb begin
    w_boundary = 1'b0;
    if (bus.i_en) begin
      if (r_mode_q == MODE_EDGE) begin
        w_boundary = (r_cnt == L_CNT_MAX);
      end else begin
        w_boundary = (r_cnt == '0) && (r_dir == DIR_DOWN);
      end
    end
  end

  // Counter/direction state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_next;
      r_dir <= w_dir_next;
    end
  end

  // Next counter state; every period restarts from 0 counting up, which also
  // makes mode switches at the boundary clean. In center mode the top value
  // is held for one extra cycle while the direction flips.
  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    if (!bus.i_en || w_boundary) begin
      w_cnt_next = '0;
      w_dir_next = DIR_UP;
    end else if (r_mode_q == MODE_EDGE) begin
      w_cnt_next = r_cnt + 1'b1;
      w_dir_next = DIR_UP;
    end else if (r_dir == DIR_UP) begin
      if (r_cnt == L_CNT_MAX) begin
        w_dir_next = DIR_DOWN;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  // Mode follows the input while stopped, otherwise only at the boundary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode_q <= MODE_EDGE;
    end else if (!bus.i_en || w_boundary) begin
      r_mode_q <= bus.i_mode;
    end
  end

  // Pending means the shadow holds a load the active registers have not seen.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
    end else if (!bus.i_en) begin
      if (bus.i_load) begin
        r_pending <= 1'b0;
      end
    end else if (w_boundary) begin
      r_pending <= 1'b0;
    end else if (bus.i_load) begin
      r_pending <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [WIDTH-1:0] L_OFFS =
      WIDTH'(stagger_offset(gi, WIDTH, CHANNELS));
    assign w_cnt_ch[gi] = (r_mode_q == MODE_EDGE) ? (r_cnt + L_OFFS) : r_cnt;
`else
    assign w_cnt_ch[gi] = r_cnt;
`endif

    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (bus.i_en),
      .i_load     (bus.i_load),
      .i_boundary (w_boundary),
      .i_duty     (bus.i_d_c[gi*WIDTH +: WIDTH]),
      .i_cnt      (w_cnt_ch[gi]),
      .o_out      (w_out[gi])
    );
  end

  assign bus.o_out        = w_out;
  assign bus.o_pending    = r_pending;
  assign bus.o_period_end = w_boundary;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel (WIDTH=4, CHANNELS=2). Stimulus queues one
// expected record per PWM period; the monitor closes a window on each period
// end and compares high-time, period length, last rising-edge position and
// whether PENDING was seen.
module tb_pwm_multichannel;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;

`ifdef PWM_PHASE_STAGGER_EN
  localparam int R1E  = 8;   // channel 1 rises half a period late
  localparam int R1E1 = 8;
`else
  localparam int R1E  = 0;
  localparam int R1E1 = -1;  // high already at the seam from center mode
`endif

  logic clk;
  logic rst_n;

  pwm_multichannel_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus();

  pwm_multichannel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h0;
    int h1;
    int len;
    int r0;
    int r1;
    int pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int h0, input int h1, input int len,
                      input int r0, input int r1, input int pend);
    exp_t e;
    e.h0 = h0; e.h1 = h1; e.len = len; e.r0 = r0; e.r1 = r1; e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the next cycle showing PERIOD_END.
  task automatic wait_pe();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.o_period_end) return;
    end
    check("period_end_timeout", 0, 1);
  endtask

  // ---------------- monitor ----------------
  int   acc0, acc1, wlen, lr0, lr1, pmax, nwin;
  logic p0, p1, pe_prev, en_prev, rst_prev;

  task automatic win_clear();
    acc0 = 0; acc1 = 0; wlen = 0; lr0 = -1; lr1 = -1; pmax = 0;
  endtask

  task automatic win_add();
    if (bus.o_out[0] && !p0) lr0 = wlen;
    if (bus.o_out[1] && !p1) lr1 = wlen;
    acc0 += int'(bus.o_out[0]);
    acc1 += int'(bus.o_out[1]);
    if (bus.o_pending) pmax = 1;
    wlen++;
  endtask

  initial begin
    exp_t e;
    win_clear();
    p0 = 1'b0; p1 = 1'b0; pe_prev = 1'b0; en_prev = 1'b0; rst_prev = 1'b0;
    nwin = 0;
    forever begin
      @(negedge clk);
      // OUT lags the counter by one cycle, so a window closes one sample
      // after the PERIOD_END cycle.
      if (pe_prev) begin
        win_add();
        nwin++;
        $display("period %0d: hi0=%0d hi1=%0d len=%0d rise0=%0d rise1=%0d pend=%0d",
                 nwin, acc0, acc1, wlen, lr0, lr1, pmax);
        if (exp_q.size() == 0) begin
          check("unexpected_period", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("high_ch0", acc0, e.h0);
          check("high_ch1", acc1, e.h1);
          check("period_len", wlen, e.len);
          check("rise_ch0", lr0, e.r0);
          check("rise_ch1", lr1, e.r1);
          check("pending_seen", pmax, e.pend);
        end
        win_clear();
      end else if (!bus.i_en || !rst_n || !en_prev || !rst_prev) begin
        win_clear();
      end else begin
        win_add();
      end
      p0 = bus.o_out[0];
      p1 = bus.o_out[1];
      pe_prev  = bus.o_period_end;
      en_prev  = bus.i_en;
      rst_prev = rst_n;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.i_en = 1'b0; bus.i_mode = 1'b0; bus.i_load = 1'b0; bus.i_d_c = '0;

    // Reset state, then run with zero duties.
    tick(3);
    check("rst_out", int'(bus.o_out), 0);
    check("rst_pending", int'(bus.o_pending), 0);
    check("rst_period_end", int'(bus.o_period_end), 0);
    repeat (4) push(0, 0, 16, -1, -1, 0);
    rst_n = 1'b1; bus.i_en = 1'b1;
    repeat (4) wait_pe();

    // Stopped: load goes straight to the active duties.
    tick(1);
    bus.i_en = 1'b0;
    tick(2);
    check("idle_out", int'(bus.o_out), 0);
    check("idle_period_end", int'(bus.o_period_end), 0);
    bus.i_d_c = {4'd8, 4'd4}; bus.i_load = 1'b1;
    tick(1);
    bus.i_load = 1'b0;
    check("idle_load_pending", int'(bus.o_pending), 0);
    repeat (2) push(4, 8, 16, 0, R1E, 0);
    bus.i_en = 1'b1;
    repeat (2) wait_pe();

    // Load at CNT=5: old duties finish the period, new ones from next CNT=0.
    push(4, 8, 16, 0, R1E, 1);
    repeat (2) push(15, 2, 16, 0, R1E, 0);
    tick(6);
    bus.i_d_c = {4'd2, 4'd15}; bus.i_load = 1'b1;
    tick(1);
    bus.i_load = 1'b0;
    check("midload_pending", int'(bus.o_pending), 1);
    wait_pe();
    tick(1);
    check("boundary_clears_pending", int'(bus.o_pending), 0);
    repeat (2) wait_pe();

    // Load exactly in the boundary cycle.
    push(15, 2, 16, 0, R1E, 0);
    repeat (2) push(1, 6, 16, 0, R1E, 0);
    tick(16);
    bus.i_d_c = {4'd6, 4'd1}; bus.i_load = 1'b1;
    wait_pe();
    tick(1);
    bus.i_load = 1'b0;
    check("boundary_load_pending", int'(bus.o_pending), 0);
    repeat (2) wait_pe();

    // Two loads mid-period (last wins) plus switch to center mode; then a
    // mode change mid center period only applies after PERIOD_END.
    push(1, 6, 16, 0, R1E, 1);
    repeat (3) push(6, 10, 32, 29, 27, 0);
    push(3, 5, 16, -1, R1E1, 0);
    push(3, 5, 16, 0, R1E, 0);
    tick(5);
    bus.i_d_c = {4'd9, 4'd9}; bus.i_load = 1'b1;
    tick(1);
    bus.i_load = 1'b0;
    tick(1);
    bus.i_d_c = {4'd5, 4'd3}; bus.i_load = 1'b1; bus.i_mode = 1'b1;
    tick(1);
    bus.i_load = 1'b0;
    repeat (3) wait_pe();
    tick(10);
    bus.i_mode = 1'b0;
    repeat (3) wait_pe();

    // One-cycle reset mid-period clears active duties and restarts at 0.
    tick(7);
    rst_n = 1'b0;
    tick(1);
    check("midrst_out", int'(bus.o_out), 0);
    check("midrst_pending", int'(bus.o_pending), 0);
    check("midrst_period_end", int'(bus.o_period_end), 0);
    repeat (4) push(0, 0, 16, -1, -1, 0);
    rst_n = 1'b1;
    repeat (4) wait_pe();

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
